decode_ctrl_stage: RTL and testbench
====================================

# decode_ctrl_stage

Registered, handshaked instruction-decode control stage for the RISC-V core, sitting between fetch and execute. Decodes R-type, I-type ALU, load, JALR and SYSTEM instructions into ALU control, write-enable and operand-select signals, holds results in a one-entry output register with valid/ready flow control, models a multi-cycle MUL by stalling, and raises a sticky `halted` on ECALL/EBREAK or an illegal instruction.

## Interface
- `XLEN`, 32: immediate width; must be 32 or 64.
- `MUL_CYCLES`, 4: cycles from accepting a MUL to presenting it; must be 1 or greater.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: stage accepts `instr` this cycle.
- `instr` input 32: raw instruction word.
- `out_valid` output 1: decoded packet valid.
- `out_ready` input 1: downstream consumes the packet.
- `alu_control` output 4: ALU operation code.
- `regwrite` output 1: write `rd`.
- `mem_read` output 1: load.
- `is_jalr` output 1: JALR.
- `use_imm` output 1: operand B is `imm`.
- `imm` output XLEN: `instr[31:20]` sign-extended.
- `rd`, `rs1`, `rs2` output 5 each: `instr[11:7]`, `[19:15]`, `[24:20]`.
- `illegal` output 1: the packet is an undecodable instruction.
- `halted` output 1: sticky halt.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111, SRA 1000.
- Opcode 0x33: funct3 0 selects ADD when funct7=0 and SUB when funct7=0x20. funct3 1 is SLL, 2 is MUL, 4 is XOR, 6 is OR, 7 is AND. funct3 5 is SRL when funct7=0 and SRA when funct7=0x20. Sets `regwrite`=1, `use_imm`=0.
- Opcode 0x13: funct3 0/1/4/5/6/7 map to ADDI/SLLI/XORI/SRLI-SRAI (selected by `instr[30]`)/ORI/ANDI. Sets `regwrite`=1, `use_imm`=1.
- Opcode 0x03: ADD, `regwrite`=1, `use_imm`=1, `mem_read`=1.
- Opcode 0x67 with funct3=0: ADD, `regwrite`=1, `use_imm`=1, `is_jalr`=1.
- Opcode 0x73 with funct3=0 (ECALL/EBREAK): ADD, all enables 0. This is a halt packet.
- Any other encoding, including undefined funct3/funct7 combinations: `illegal`=1, ADD, all enables 0. This is also a halt packet.
- FSM states:
  - RUN: `in_ready` = !`out_valid` || `out_ready`. On accept, a non-MUL instruction loads the output register. A MUL with `MUL_CYCLES`>1 loads the fields, keeps `out_valid` low, sets cnt=`MUL_CYCLES`-1, and moves to MUL_WAIT.
  - MUL_WAIT: `in_ready`=0 and cnt decrements each cycle. At cnt=1, the next edge sets `out_valid` and returns to RUN.
  - HALTED: `in_ready`=0 and `halted`=1. Only reset exits this state.
- RUN moves to HALTED on the edge where a halt packet is consumed (`out_valid`&&`out_ready`). Instructions after the halt packet are not accepted.
- If no new accept occurs, consuming a packet clears `out_valid`.

## Timing
- Reset (asynchronous assert, synchronous release): state RUN, every output register 0, `halted`=0. This gives `in_ready`=1 and `out_valid`=0.
- Non-MUL latency is 1 cycle: a packet accepted at edge N has `out_valid`=1 after edge N.
- MUL latency is `MUL_CYCLES` cycles from accept to `out_valid`.
- Throughput is one instruction per cycle when `out_ready`=1. Accept and consume in the same cycle is legal and replaces the packet with no bubble.
- While `out_valid`=1 and `out_ready`=0, all output fields and `out_valid` hold stable, and `in_ready`=0.
- `in_ready` depends combinationally on `out_ready`. All other outputs are registered.
- Reset asserted mid-MUL or mid-stall drops the in-flight packet immediately.

## Test plan
- Back-to-back R-type ADD (funct7=0), SUB (0x20), XOR, SRA with `out_ready`=1 -> packets on consecutive cycles with codes 0010, 0100, 0111, 1000 and `regwrite`=1.
- ADDI x1,x0,-1 (0xFFF00093), `XLEN`=64 -> `imm`=0xFFFF_FFFF_FFFF_FFFF, `use_imm`=1, `rd`=1.
- MUL with `MUL_CYCLES`=4, followed immediately by ADD -> MUL `out_valid` rises 4 cycles after accept, `in_ready`=0 for 3 cycles, and ADD follows the next cycle.
- `out_ready` held low for 5 cycles on an LW packet -> `mem_read`=1 and all fields stable throughout, `in_ready`=0, no instruction lost.
- ECALL (0x00000073) followed by ADD with `in_valid`=1 -> one halt packet, then `halted`=1 and `in_ready`=0 permanently, and the ADD is never output.
- Opcode 0x7F -> `illegal`=1, `regwrite`=0, `halted` after consumption. Then `rst_n` pulsed low -> all outputs 0 and `in_ready`=1.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// Decode stage: RV control decode into a one-entry valid/ready output register, MUL stall, sticky halt.
// Latency: 1 cycle for non-MUL, MUL_CYCLES cycles for MUL.
// Backpressure: in_ready follows out_ready combinationally; the held packet stays stable while stalled.
module decode_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic            regwrite,
  output logic            mem_read,
  output logic            is_jalr,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal,
  output logic            halted
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef struct packed {
    logic [3:0]      alu;
    logic            regwrite;
    logic            mem_read;
    logic            is_jalr;
    logic            use_imm;
    logic            illegal;
    logic            halt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } pkt_t;

  typedef enum logic [1:0] {RUN, MUL_WAIT, HALTED} state_t;

  state_t           state_q, state_d;
  pkt_t             pkt_q, pkt_d, dec;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_mul, legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shamt_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // RV64 shift immediates use bit 25 as shamt[5]; RV32 requires it clear.
  assign shamt_ok = (instr[29:26] == 4'b0) && !instr[31] && ((XLEN == 64) || !instr[25]);

  always_comb begin
    dec          = '0;
    dec.alu      = ALU_ADD;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
    dec_mul      = 1'b0;
    legal        = 1'b1;
    case (opcode)
      7'h33: begin
        dec.regwrite = 1'b1;
        case (funct3)
          3'd0: begin
            if (funct7 == 7'h00)      dec.alu = ALU_ADD;
            else if (funct7 == 7'h20) dec.alu = ALU_SUB;
            else                      legal   = 1'b0;
          end
          3'd1: begin
            dec.alu = ALU_SLL;
            legal   = (funct7 == 7'h00);
          end
          3'd2: begin
            dec.alu = ALU_MUL;
            dec_mul = 1'b1;
            legal   = (funct7 == 7'h00) || (funct7 == 7'h01);
          end
          3'd4: begin
            dec.alu = ALU_XOR;
            legal   = (funct7 == 7'h00);
          end
          3'd5: begin
            if (funct7 == 7'h00)      dec.alu = ALU_SRL;
            else if (funct7 == 7'h20) dec.alu = ALU_SRA;
            else                      legal   = 1'b0;
          end
          3'd6: begin
            dec.alu = ALU_OR;
            legal   = (funct7 == 7'h00);
          end
          3'd7: begin
            dec.alu = ALU_AND;
            legal   = (funct7 == 7'h00);
          end
          default: legal = 1'b0;
        endcase
      end
      7'h13: begin
        dec.regwrite = 1'b1;
        dec.use_imm  = 1'b1;
        case (funct3)
          3'd0: dec.alu = ALU_ADD;
          3'd1: begin
            dec.alu = ALU_SLL;
            legal   = shamt_ok && !instr[30];
          end
          3'd4: dec.alu = ALU_XOR;
          3'd5: begin
            dec.alu = instr[30] ? ALU_SRA : ALU_SRL;
            legal   = shamt_ok;
          end
          3'd6: dec.alu = ALU_OR;
          3'd7: dec.alu = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      7'h03: begin
        dec.regwrite = 1'b1;
        dec.use_imm  = 1'b1;
        dec.mem_read = 1'b1;
      end
      7'h67: begin
        dec.regwrite = 1'b1;
        dec.use_imm  = 1'b1;
        dec.is_jalr  = 1'b1;
        legal        = (funct3 == 3'd0);
      end
      7'h73: begin
        dec.halt = 1'b1;
        legal    = (funct3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alu      = ALU_ADD;
      dec.regwrite = 1'b0;
      dec.mem_read = 1'b0;
      dec.is_jalr  = 1'b0;
      dec.use_imm  = 1'b0;
      dec.illegal  = 1'b1;
      dec.halt     = 1'b1;
      dec_mul      = 1'b0;
    end
  end

  // A held halt packet blocks intake so nothing behind it is ever accepted.
  assign in_ready = (state_q == RUN) && !(out_valid_q && pkt_q.halt) &&
                    (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      RUN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (pkt_q.halt) state_d = HALTED;
        end
        if (in_valid && in_ready) begin
          pkt_d = dec;
          if (dec_mul && (MUL_CYCLES > 1)) begin
            out_valid_d = 1'b0;
            cnt_d       = CNT_W'(MUL_CYCLES - 1);
            state_d     = MUL_WAIT;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          out_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      HALTED: begin
        out_valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pkt_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = pkt_q.alu;
  assign regwrite    = pkt_q.regwrite;
  assign mem_read    = pkt_q.mem_read;
  assign is_jalr     = pkt_q.is_jalr;
  assign use_imm     = pkt_q.use_imm;
  assign illegal     = pkt_q.illegal;
  assign imm         = pkt_q.imm;
  assign rd          = pkt_q.rd;
  assign rs1         = pkt_q.rs1;
  assign rs2         = pkt_q.rs2;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage (XLEN=64, MUL_CYCLES=4) with hand-computed expectations.
module tb_decode_ctrl_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_control;
  logic            regwrite;
  logic            mem_read;
  logic            is_jalr;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            illegal;
  logic            halted;

  int n_checks = 0;
  int n_pass   = 0;

  decode_ctrl_stage #(.XLEN(XLEN), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .regwrite(regwrite), .mem_read(mem_read), .is_jalr(is_jalr), .use_imm(use_imm),
    .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_instr [4];
  logic [3:0]  vec_alu   [4];
  logic [31:0] i_add, i_xor, i_mul, i_lw;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    i_add = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    i_xor = rtype(7'h00, 5'd7, 5'd6, 3'd4, 5'd9);
    i_mul = rtype(7'h00, 5'd2, 5'd1, 3'd2, 5'd4);
    i_lw  = {12'd8, 5'd2, 3'd2, 5'd5, 7'h03};
    vec_instr[0] = i_add;                                vec_alu[0] = 4'b0010;
    vec_instr[1] = rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd3); vec_alu[1] = 4'b0100;
    vec_instr[2] = i_xor;                                vec_alu[2] = 4'b0111;
    vec_instr[3] = rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd3); vec_alu[3] = 4'b1000;

    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_halted", halted, 0);
    check("rst_alu", alu_control, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back R-type stream, one packet per cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = vec_instr[i];
      tick();
      check($sformatf("b2b_valid%0d", i), out_valid, 1);
      check($sformatf("b2b_alu%0d", i), alu_control, vec_alu[i]);
      check($sformatf("b2b_regwrite%0d", i), regwrite, 1);
      check($sformatf("b2b_use_imm%0d", i), use_imm, 0);
    end
    check("b2b_rd", rd, 3);
    check("b2b_in_ready", in_ready, 1);

    // ADDI x1,x0,-1 sign-extends to 64 bits.
    instr = 32'hFFF00093;
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_use_imm", use_imm, 1);
    check("addi_rd", rd, 1);
    check("addi_alu", alu_control, 4'b0010);

    // MUL then ADD: three stalled samples, MUL presented, ADD right after.
    instr = i_mul;
    tick();
    instr = i_add;
    check("mul_wait_valid0", out_valid, 0);
    check("mul_wait_rdy0", in_ready, 0);
    for (int k = 1; k < 3; k++) begin
      tick();
      check($sformatf("mul_wait_valid%0d", k), out_valid, 0);
      check($sformatf("mul_wait_rdy%0d", k), in_ready, 0);
    end
    tick();
    check("mul_valid", out_valid, 1);
    check("mul_alu", alu_control, 4'b0110);
    check("mul_rd", rd, 4);
    check("mul_in_ready", in_ready, 1);
    tick();
    check("post_mul_add_valid", out_valid, 1);
    check("post_mul_add_alu", alu_control, 4'b0010);
    check("post_mul_add_rd", rd, 3);

    // LW held for 5 cycles with a pending XOR behind it.
    instr = i_lw;
    tick();
    out_ready = 1'b0;
    instr = i_xor;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_valid%0d", k), out_valid, 1);
      check($sformatf("stall_mem_read%0d", k), mem_read, 1);
      check($sformatf("stall_rd%0d", k), rd, 5);
      check($sformatf("stall_imm%0d", k), imm, 8);
      check($sformatf("stall_rdy%0d", k), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    tick();
    check("after_stall_valid", out_valid, 1);
    check("after_stall_alu", alu_control, 4'b0111);
    check("after_stall_mem_read", mem_read, 0);
    check("after_stall_rd", rd, 9);

    // ECALL then ADD: the ADD is never taken.
    instr = 32'h00000073;
    tick();
    instr = i_add;
    check("ecall_valid", out_valid, 1);
    check("ecall_regwrite", regwrite, 0);
    check("ecall_illegal", illegal, 0);
    check("ecall_alu", alu_control, 4'b0010);
    check("ecall_in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("halt_flag%0d", k), halted, 1);
      check($sformatf("halt_valid%0d", k), out_valid, 0);
      check($sformatf("halt_rdy%0d", k), in_ready, 0);
    end

    // Reset clears the halt; then an illegal opcode halts again.
    rst_n = 1'b0;
    #1;
    check("rst2_halted", halted, 0);
    check("rst2_in_ready", in_ready, 1);
    rst_n = 1'b1;
    instr = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    check("illegal_valid", out_valid, 1);
    check("illegal_flag", illegal, 1);
    check("illegal_regwrite", regwrite, 0);
    check("illegal_alu", alu_control, 4'b0010);
    check("illegal_in_ready", in_ready, 0);
    tick();
    check("illegal_halted", halted, 1);
    check("illegal_consumed", out_valid, 0);

    rst_n = 1'b0;
    #1;
    check("rst3_valid", out_valid, 0);
    check("rst3_illegal", illegal, 0);
    check("rst3_halted", halted, 0);
    check("rst3_in_ready", in_ready, 1);
    check("rst3_alu", alu_control, 0);
    check("rst3_imm", imm, 0);
    check("rst3_rd", rd, 0);
    check("rst3_regwrite", regwrite, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
